// File: rtl/led_pattern_sequencer.sv
// ============================================================================
// Module   : led_pattern_sequencer
// Purpose  : Plays a loaded LED on/off mask MSB-first, one bit per prescaler
//            period, for a programmed number of passes (0 = forever).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_pattern_sequencer #(
  parameter int CBITS = 26,
  parameter int MBITS = 16,
  parameter int RBITS = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [MBITS-1:0] i_mask,
  input  logic [RBITS-1:0] i_repeat,
  input  logic             i_stop,
  output logic             o_led,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_step
);

  localparam int IBITS = (MBITS > 1) ? $clog2(MBITS) : 1;
  localparam logic [IBITS-1:0] LAST_IDX = IBITS'(MBITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [CBITS-1:0] presc, presc_n;
  logic [IBITS-1:0] index, index_n;
  logic [MBITS-1:0] mask, mask_n;
  logic [RBITS-1:0] remaining, remaining_n;
  logic             forever_mode, forever_n;
  logic             led, led_n;
  logic             wrap;

  assign wrap = (state == RUN) && (presc == '1);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= IDLE;
      presc        <= '0;
      index        <= '0;
      mask         <= '0;
      remaining    <= '0;
      forever_mode <= 1'b0;
      led          <= 1'b0;
    end else begin
      state        <= state_n;
      presc        <= presc_n;
      index        <= index_n;
      mask         <= mask_n;
      remaining    <= remaining_n;
      forever_mode <= forever_n;
      led          <= led_n;
    end
  end

  always_comb begin
    state_n     = state;
    presc_n     = presc;
    index_n     = index;
    mask_n      = mask;
    remaining_n = remaining;
    forever_n   = forever_mode;
    led_n       = led;

    // Stop outranks load in every state; in IDLE it leaves nothing to change.
    if (i_stop) begin
      state_n = IDLE;
      presc_n = '0;
      led_n   = 1'b0;
    end else if (i_load) begin
      state_n     = RUN;
      presc_n     = '0;
      index_n     = LAST_IDX;
      mask_n      = i_mask;
      remaining_n = i_repeat;
      forever_n   = (i_repeat == '0);
      led_n       = i_mask[MBITS-1];
    end else begin
      case (state)
        RUN: begin
          presc_n = presc + CBITS'(1);
          if (wrap) begin
            if (index != '0) begin
              index_n = index - IBITS'(1);
              led_n   = mask[index - IBITS'(1)];
            end else if (forever_mode || (remaining > RBITS'(1))) begin
              if (!forever_mode) begin
                remaining_n = remaining - RBITS'(1);
              end
              index_n = LAST_IDX;
              led_n   = mask[MBITS-1];
            end else begin
              state_n = DONE;
              led_n   = 1'b0;
            end
          end
        end
        DONE:    state_n = IDLE;
        default: state_n = state;
      endcase
    end
  end

  assign o_led  = led;
  assign o_busy = (state == RUN);
  assign o_done = (state == DONE);
  assign o_step = wrap;

endmodule

`default_nettype wire

// File: tb/tb_led_pattern_sequencer.sv
// ============================================================================
// Module   : tb_led_pattern_sequencer
// Purpose  : Self-checking bench: vector table, directed corner sequences and
//            random stimulus against an elapsed-time reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_pattern_sequencer;

  localparam int CBITS = 2;
  localparam int MBITS = 4;
  localparam int RBITS = 4;
  localparam int STEP  = 1 << CBITS;
  localparam int PASS  = MBITS * STEP;

  logic             clk = 1'b0;
  logic             reset, load, stop;
  logic [MBITS-1:0] mask;
  logic [RBITS-1:0] rep;
  logic             led, busy, done, step;

  always #5 clk = ~clk;

  led_pattern_sequencer #(.CBITS(CBITS), .MBITS(MBITS), .RBITS(RBITS)) dut (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_load   (load),
    .i_mask   (mask),
    .i_repeat (rep),
    .i_stop   (stop),
    .o_led    (led),
    .o_busy   (busy),
    .o_done   (done),
    .o_step   (step)
  );

  int tests = 0;
  int fails = 0;

  // Model: t counts cycles since load (t=1 is the first cycle after it).
  bit               m_active = 1'b0;
  int               m_t      = 0;
  logic [MBITS-1:0] m_mask   = '0;
  int               m_rep    = 0;

  function automatic void model_edge();
    if (reset || stop) begin
      m_active = 1'b0;
    end else if (load) begin
      m_active = 1'b1;
      m_t      = 1;
      m_mask   = mask;
      m_rep    = int'(rep);
    end else if (m_active) begin
      m_t++;
      if (m_rep != 0 && m_t > m_rep * PASS + 1) m_active = 1'b0;
    end
  endfunction

  // Returns {led, busy, done, step}.
  function automatic logic [3:0] model_out();
    int bitpos;
    if (!m_active) return 4'b0000;
    if (m_rep != 0 && m_t == m_rep * PASS + 1) return 4'b0010;
    bitpos = (MBITS - 1) - (((m_t - 1) % PASS) / STEP);
    return {m_mask[bitpos], 1'b1, 1'b0, (m_t % STEP) == 0};
  endfunction

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s t=%0t got {led,busy,done,step}=%b expected %b", name, $time, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("model", {led, busy, done, step}, model_out());
    load = 1'b0;
    stop = 1'b0;
  endtask

  typedef struct {
    logic             rst;
    logic             ld;
    logic             sp;
    logic [MBITS-1:0] mk;
    logic [RBITS-1:0] rp;
    logic [3:0]       exp;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic l, input logic s,
                              input logic [MBITS-1:0] m, input logic [RBITS-1:0] p,
                              input logic [3:0] e);
    vec_t v;
    v.rst = r; v.ld = l; v.sp = s; v.mk = m; v.rp = p; v.exp = e;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [15:0] led_seq;
    int busy_cnt, done_cnt, k;
    bit  seen;

    reset = 1'b1; load = 1'b0; stop = 1'b0; mask = '0; rep = '0;

    // Reset, idle, then a single pass of 1011 with hand-derived expectations.
    led_seq = 16'b1111_0000_1111_1111;
    for (int i = 0; i < 3; i++)  add(1'b1, 1'b0, 1'b0, 4'b0000, 4'd0, 4'b0000);
    for (int i = 0; i < 20; i++) add(1'b0, 1'b0, 1'b0, 4'b0000, 4'd0, 4'b0000);
    add(1'b0, 1'b1, 1'b0, 4'b1011, 4'd1, 4'b1100);
    for (int c = 2; c <= 16; c++)
      add(1'b0, 1'b0, 1'b0, 4'b0000, 4'd0,
          {led_seq[16-c], 1'b1, 1'b0, (c % 4) == 0});
    add(1'b0, 1'b0, 1'b0, 4'b0000, 4'd0, 4'b0010);
    add(1'b0, 1'b0, 1'b0, 4'b0000, 4'd0, 4'b0000);

    foreach (vecs[i]) begin
      reset = vecs[i].rst; load = vecs[i].ld; stop = vecs[i].sp;
      mask  = vecs[i].mk;  rep  = vecs[i].rp;
      tick();
      check($sformatf("table[%0d]", i), {led, busy, done, step}, vecs[i].exp);
    end

    // Multi-pass: three passes of 1000.
    mask = 4'b1000; rep = 4'd3; load = 1'b1;
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      busy_cnt += int'(busy);
      done_cnt += int'(done);
    end
    check_int("multipass_busy_cycles", busy_cnt, 48);
    check_int("multipass_done_pulses", done_cnt, 1);

    // Forever mode, then stop.
    mask = 4'b0101; rep = 4'd0; load = 1'b1;
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      busy_cnt += int'(busy);
      done_cnt += int'(done);
    end
    check_int("forever_busy_cycles", busy_cnt, 200);
    stop = 1'b1;
    tick();
    check("stop_next_cycle", {led, busy, done, step}, 4'b0000);
    for (int i = 0; i < 20; i++) begin
      tick();
      done_cnt += int'(done);
    end
    check_int("forever_no_done", done_cnt, 0);

    // Restart during RUN: prescaler must restart from zero.
    mask = 4'b0011; rep = 4'd2; load = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    mask = 4'b1111; load = 1'b1;
    tick();
    check("restart_led", {led, busy, done, step}, 4'b1100);
    k = 1; seen = 1'b0;
    while (!seen && k < 12) begin
      tick();
      k++;
      seen = step;
    end
    check_int("restart_step_distance", k, 4);
    mask = 4'b1010; rep = 4'd1; load = 1'b1; stop = 1'b1;
    tick();
    check("load_stop_priority", {led, busy, done, step}, 4'b0000);

    // Reset in the middle of pass 2, then a fresh load.
    mask = 4'b1000; rep = 4'd3; load = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    reset = 1'b1;
    tick();
    check("midrun_reset", {led, busy, done, step}, 4'b0000);
    reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      done_cnt += int'(done);
    end
    check_int("midrun_reset_no_done", done_cnt, 0);
    mask = 4'b1000; rep = 4'd1; load = 1'b1;
    tick();
    check("reload_after_reset", {led, busy, done, step}, 4'b1100);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      load  = ($urandom_range(0, 24) == 0);
      stop  = ($urandom_range(0, 59) == 0);
      mask  = MBITS'($urandom);
      rep   = RBITS'($urandom_range(0, 3));
      tick();
      reset = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
